countdown_timer: RTL and testbench

Loadable, prescaled down-counter that mirrors the team's loadable up-counter. It counts a programmed value down to zero and signals terminal count. It supports one-shot and auto-reload modes, plus pause, resume and abort. It sits beside the up-counter in the same tile and is driven from the dedicated input pins and the bidirectional input pins; its count is visible on the output pins.

---
 rtl/timer_pkg.sv | 13 +
 rtl/prescale_divider.sv | 35 +++
 rtl/countdown_timer.sv | 114 +++++++++++
 tb/tb_countdown_timer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and defaults for the countdown timer and its prescale divider.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_PRESCALE_W = 8;

endpackage

// File: rtl/prescale_divider.sv
// Tick generator: one-cycle tick every prescale+1 enabled cycles; load captures the period.
// Combinational tick from the registered pre counter; holds its state while enable is low.
module prescale_divider
  import timer_pkg::*;
#(
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] period;
  logic [PRESCALE_W-1:0] pre;

  assign tick = enable && !load && (pre == '0);

  // The period is captured at load so later changes on the prescale pins do not disturb a run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period <= '0;
      pre    <= '0;
    end else if (load) begin
      period <= prescale;
      pre    <= prescale;
    end else if (enable) begin
      if (pre == '0) pre <= period;
      else           pre <= pre - PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable prescaled down-counter with one-shot/auto-reload, pause, resume and abort.
// All outputs registered; first decrement prescale+1 cycles after start, stop beats start.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  auto_reload,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  tc_pulse,
  output logic                  done
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic             done_nxt;
  logic             pre_load;
  logic             pre_en;
  logic             tick;
  logic             load_zero;

  assign load_zero = (load_val == '0);

  prescale_divider #(
    .PRESCALE_W (PRESCALE_W)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .enable   (pre_en),
    .load     (pre_load),
    .prescale (prescale),
    .tick     (tick)
  );

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    tc_nxt    = 1'b0;
    done_nxt  = done;
    pre_load  = 1'b0;
    pre_en    = 1'b0;
    // A start from IDLE or RUN (re)launches the run; a zero load completes immediately.
    if (start && !stop && (state != PAUSE)) begin
      if (load_zero) begin
        count_nxt = '0;
        tc_nxt    = 1'b1;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end else begin
        count_nxt = load_val;
        pre_load  = 1'b1;
        done_nxt  = 1'b0;
        state_nxt = RUN;
      end
    end else begin
      unique case (state)
        IDLE: state_nxt = IDLE;
        RUN: begin
          if (stop) begin
            state_nxt = PAUSE;
          end else begin
            pre_en = 1'b1;
            if (tick) begin
              if (count > WIDTH'(1)) begin
                count_nxt = count - WIDTH'(1);
              end else if (count == WIDTH'(1)) begin
                tc_nxt = 1'b1;
                if (auto_reload && !load_zero) begin
                  count_nxt = load_val;
                end else begin
                  count_nxt = '0;
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
                end
              end
            end
          end
        end
        PAUSE: begin
          if (stop)       state_nxt = IDLE;
          else if (start) state_nxt = RUN;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      busy     <= 1'b0;
      tc_pulse <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      busy     <= (state_nxt != IDLE);
      tc_pulse <= tc_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer; outputs sampled on the falling clock edge.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] load_val;
  logic [7:0] prescale;
  logic       start;
  logic       stop;
  logic       auto_reload;
  logic [7:0] count;
  logic       busy;
  logic       tc_pulse;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  countdown_timer #(.WIDTH(8), .PRESCALE_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_val    (load_val),
    .prescale    (prescale),
    .start       (start),
    .stop        (stop),
    .auto_reload (auto_reload),
    .count       (count),
    .busy        (busy),
    .tc_pulse    (tc_pulse),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Returns at the falling edge just after the rising edge that captured start.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; load_val = 8'd0; prescale = 8'd0;
    start = 1'b0; stop = 1'b0; auto_reload = 1'b0;
    #3;
    n_vec++; if (count !== 8'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (tc_pulse !== 1'b0) begin n_err++; $display("FAIL reset_tc got %b want 0", tc_pulse); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_oneshot();
    logic [7:0] ec;
    load_val = 8'd3; prescale = 8'd0; auto_reload = 1'b0;
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      ec = (k < 3) ? 8'(3 - k) : 8'd0;
      n_vec++; if (count !== ec) begin n_err++; $display("FAIL oneshot_count k=%0d got %0d want %0d", k, count, ec); end
      n_vec++; if (tc_pulse !== (k == 3)) begin n_err++; $display("FAIL oneshot_tc k=%0d got %b want %b", k, tc_pulse, k == 3); end
      n_vec++; if (busy !== (k < 3)) begin n_err++; $display("FAIL oneshot_busy k=%0d got %b want %b", k, busy, k < 3); end
      n_vec++; if (done !== (k >= 3)) begin n_err++; $display("FAIL oneshot_done k=%0d got %b want %b", k, done, k >= 3); end
    end
  endtask

  task automatic test_prescaled();
    logic [7:0] ec;
    load_val = 8'd2; prescale = 8'd2; auto_reload = 1'b0;
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      ec = (k < 3) ? 8'd2 : (k < 6) ? 8'd1 : 8'd0;
      n_vec++; if (count !== ec) begin n_err++; $display("FAIL presc_count k=%0d got %0d want %0d", k, count, ec); end
      n_vec++; if (tc_pulse !== (k == 6)) begin n_err++; $display("FAIL presc_tc k=%0d got %b want %b", k, tc_pulse, k == 6); end
      n_vec++; if (busy !== (k < 6)) begin n_err++; $display("FAIL presc_busy k=%0d got %b want %b", k, busy, k < 6); end
      n_vec++; if (done !== (k >= 6)) begin n_err++; $display("FAIL presc_done k=%0d got %b want %b", k, done, k >= 6); end
    end
  endtask

  task automatic test_auto_reload();
    logic [7:0] ec;
    logic       et;
    load_val = 8'd2; prescale = 8'd0; auto_reload = 1'b1;
    pulse_start();
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      ec = (k == 8) ? 8'd0 : (k % 2 == 0) ? 8'd2 : 8'd1;
      et = (k > 0) && (k % 2 == 0);
      n_vec++; if (count !== ec) begin n_err++; $display("FAIL reload_count k=%0d got %0d want %0d", k, count, ec); end
      n_vec++; if (tc_pulse !== et) begin n_err++; $display("FAIL reload_tc k=%0d got %b want %b", k, tc_pulse, et); end
      n_vec++; if (busy !== (k < 8)) begin n_err++; $display("FAIL reload_busy k=%0d got %b want %b", k, busy, k < 8); end
      n_vec++; if (done !== (k == 8)) begin n_err++; $display("FAIL reload_done k=%0d got %b want %b", k, done, k == 8); end
      if (k == 6) auto_reload = 1'b0;
    end
  endtask

  task automatic test_pause();
    logic [7:0] ec;
    load_val = 8'd5; prescale = 8'd1; auto_reload = 1'b0;
    pulse_start();
    repeat (4) @(negedge clk);
    n_vec++; if (count !== 8'd3) begin n_err++; $display("FAIL pause_pre_count got %0d want 3", count); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_vec++; if (count !== 8'd3) begin n_err++; $display("FAIL pause_hold_count i=%0d got %0d want 3", i, count); end
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL pause_hold_busy i=%0d got %b want 1", i, busy); end
      @(negedge clk);
    end
    pulse_start();
    for (int j = 0; j < 7; j++) begin
      if (j > 0) @(negedge clk);
      ec = (j == 6) ? 8'd0 : 8'(3 - j / 2);
      n_vec++; if (count !== ec) begin n_err++; $display("FAIL resume_count j=%0d got %0d want %0d", j, count, ec); end
      n_vec++; if (tc_pulse !== (j == 6)) begin n_err++; $display("FAIL resume_tc j=%0d got %b want %b", j, tc_pulse, j == 6); end
      n_vec++; if (busy !== (j < 6)) begin n_err++; $display("FAIL resume_busy j=%0d got %b want %b", j, busy, j < 6); end
    end
    // Second run: pause then abort.
    pulse_start();
    repeat (4) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL abort_paused_busy got %b want 1", busy); end
    @(negedge clk);
    stop = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", busy); end
    n_vec++; if (count !== 8'd3) begin n_err++; $display("FAIL abort_count got %0d want 3", count); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_done got %b want 0", done); end
    n_vec++; if (tc_pulse !== 1'b0) begin n_err++; $display("FAIL abort_tc got %b want 0", tc_pulse); end
    @(negedge clk);
    n_vec++; if (count !== 8'd3) begin n_err++; $display("FAIL abort_hold_count got %0d want 3", count); end
  endtask

  task automatic test_edges();
    load_val = 8'd0; prescale = 8'd0; auto_reload = 1'b1;
    pulse_start();
    n_vec++; if (count !== 8'd0) begin n_err++; $display("FAIL zero_count got %0d want 0", count); end
    n_vec++; if (tc_pulse !== 1'b1) begin n_err++; $display("FAIL zero_tc got %b want 1", tc_pulse); end
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL zero_done got %b want 1", done); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy got %b want 0", busy); end
    @(negedge clk);
    n_vec++; if (tc_pulse !== 1'b0) begin n_err++; $display("FAIL zero_tc_after got %b want 0", tc_pulse); end
    auto_reload = 1'b0;
    load_val = 8'd7;
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_both_busy got %b want 0", busy); end
    n_vec++; if (count !== 8'd0) begin n_err++; $display("FAIL idle_both_count got %0d want 0", count); end
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL idle_both_done got %b want 1", done); end
    pulse_start();
    n_vec++; if (count !== 8'd7) begin n_err++; $display("FAIL run_start_count got %0d want 7", count); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL run_start_done got %b want 0", done); end
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL run_both_busy got %b want 1", busy); end
    n_vec++; if (count !== 8'd7) begin n_err++; $display("FAIL run_both_count got %0d want 7", count); end
    @(negedge clk);
    n_vec++; if (count !== 8'd7) begin n_err++; $display("FAIL run_both_hold got %0d want 7", count); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL run_both_abort_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_midrun();
    logic [7:0] ec;
    load_val = 8'd200; prescale = 8'd3; auto_reload = 1'b0;
    pulse_start();
    repeat (10) @(negedge clk);
    n_vec++; if (count !== 8'd198) begin n_err++; $display("FAIL midrun_count got %0d want 198", count); end
    #2 reset = 1'b1;
    #1;
    n_vec++; if (count !== 8'd0) begin n_err++; $display("FAIL arst_count got %0d want 0", count); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL arst_busy got %b want 0", busy); end
    n_vec++; if (tc_pulse !== 1'b0) begin n_err++; $display("FAIL arst_tc got %b want 0", tc_pulse); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL arst_done got %b want 0", done); end
    @(negedge clk);
    reset = 1'b0;
    load_val = 8'd2; prescale = 8'd0;
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      ec = 8'(2 - k);
      n_vec++; if (count !== ec) begin n_err++; $display("FAIL post_rst_count k=%0d got %0d want %0d", k, count, ec); end
      n_vec++; if (tc_pulse !== (k == 2)) begin n_err++; $display("FAIL post_rst_tc k=%0d got %b want %b", k, tc_pulse, k == 2); end
      n_vec++; if (done !== (k == 2)) begin n_err++; $display("FAIL post_rst_done k=%0d got %b want %b", k, done, k == 2); end
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_prescaled();
    test_auto_reload();
    test_pause();
    test_edges();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
